vcid_demux_stage: RTL and testbench
===================================

Name: vcid_demux_stage

Overview:
- Sits directly downstream of the Main FIFO pop-condition stage.
- Consumes its 6-bit word plus valid, steers each word by its VC-id bit into the VC0 or VC1 FIFO, and buffers each path in a small per-VC skid FIFO.
- With the skid FIFOs in place, a downstream full never drops a word already popped from Main.
- Provides a busy flag that the top level ORs into the Main pop gate, plus per-VC push counters for verification.

Parameters:
DATA_W, 6, word width.
VCID_BIT, 4, bit of the input word selecting destination: 0 -> VC0, 1 -> VC1.
SKID_DEPTH, 4, entries per VC skid FIFO; must be a power of 2 and at least 2.
CNT_W, 8, width of the per-VC push counters.

Ports:
clk  in  1  clock, rising edge
reset_L  in  1  reset, synchronous, active-low
demux_vcid_in  in  DATA_W  word from the pop stage
demux_vcid_valid_in  in  1  word valid
VC0_full  in  1  VC0 FIFO full
VC1_full  in  1  VC1 FIFO full
VC0_data_out  out  DATA_W  word to VC0 FIFO
VC0_push  out  1  VC0 FIFO write strobe
VC1_data_out  out  DATA_W  word to VC1 FIFO
VC1_push  out  1  VC1 FIFO write strobe
demux_busy  out  1  either skid count >= SKID_DEPTH-1
VC0_cnt  out  CNT_W  VC0 pushes since reset
VC1_cnt  out  CNT_W  VC1 pushes since reset
overflow_err  out  1  sticky: a word arrived at a full skid FIFO

Behaviour:
- One clock domain (clk). Reset is synchronous, active-low (reset_L); it is sampled only at the rising clk edge.
- Reset: skid pointers and counts = 0, VC0_cnt = VC1_cnt = 0, overflow_err = 0. Resulting outputs: VCx_push = 0, VCx_data_out = 0, demux_busy = 0.
- Reset mid-operation discards all buffered words; nothing is pushed in the cycle after reset.
- Routing: when demux_vcid_valid_in = 1, the word is enqueued at the clock edge into skid[demux_vcid_in[VCID_BIT]]. The word is stored unmodified. Invalid input is ignored.
- Push generation: combinational from registered state only, with no input-to-output combinational path.
  - VCx_push = (skidx count != 0) && !VCx_full.
  - VCx_data_out = skid head when VCx_push = 1, else 0.
  - On an edge with VCx_push = 1, the head is dequeued and VCx_cnt increments.
- Latency: a word accepted at edge k appears on VCx_data_out/VCx_push in cycle k+1 if the skid was empty and VCx_full = 0. Minimum latency is 1 cycle.
- Throughput: one word per cycle per VC. The two VCs operate independently; a stalled VC0 never blocks VC1.
- Ordering: strict FIFO order per VC. There is no ordering relation between VCs.
- Simultaneous enqueue and dequeue on the same skid: count unchanged. This is legal even at count = SKID_DEPTH and does not raise an error.
- Overflow: enqueue with count = SKID_DEPTH and no dequeue in the same cycle -> the word is dropped and overflow_err is set. overflow_err stays at 1 until reset.
- Busy: demux_busy = (skid0 count >= SKID_DEPTH-1) || (skid1 count >= SKID_DEPTH-1), decoded from registers. This leaves one slot of margin for the word the combinational pop stage may issue in the same cycle.
- Pointers wrap modulo SKID_DEPTH. Count width is clog2(SKID_DEPTH)+1.
- Counters wrap modulo 2^CNT_W with no saturation.
- VCx_full held high: skid fills, demux_busy asserts, and no push occurs. When full deasserts, the buffered words drain one per cycle in order.

Decomposition:
- Shared package vc_pkg: DATA_W, VCID_BIT, VC0_ID = 0, VC1_ID = 1, and default SKID_DEPTH/CNT_W. These are shared with the pop and VC FIFO stages.
- One sub-module, vc_skid_fifo (DATA_W, SKID_DEPTH). It provides push, pop, head, count, full and empty, and is instantiated once per VC.
- The top level holds routing, push gating, counters, busy and the error flag.

Test Plan:
- Reset: hold reset_L = 0 with valid_in = 1 and data 6'h15 -> all outputs 0, counters 0; no push in the first cycle after release.
- Routing: data 6'h05 (bit4 = 0) then 6'h13 (bit4 = 1) on consecutive cycles, fulls low -> VC0_push with 6'h05 in the next cycle, then VC1_push with 6'h13 one cycle later; VC0_cnt = 1, VC1_cnt = 1.
- Stall and drain: VC0_full = 1, send 6'h01, 6'h02, 6'h03 to VC0 -> demux_busy = 1 after the third word; release full -> pushes 6'h01, 6'h02, 6'h03 on three consecutive cycles, then busy = 0.
- Independence: VC0_full = 1 while streaming 8 words to VC1 -> VC1 pushes every cycle at latency 1; VC0_push stays 0.
- Full-skid simultaneous: skid0 holds 4 words, VC0_full drops in the same cycle as a new VC0 word -> word accepted, overflow_err = 0; a later enqueue at count 4 with VC0_full = 1 -> overflow_err = 1 until reset.
- Counter wrap: 256 VC1 pushes -> VC1_cnt returns to 0.

Source files
------------

// File: rtl/vcid_demux_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vc_pkg
// Description : Constants shared by the Main pop stage, the VC-id demux
//               stage and the VC FIFOs: word width, VC-id select bit, VC
//               identifiers and default sizing of the demux skid buffers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package vc_pkg;

  localparam int DATA_W     = 6;
  localparam int VCID_BIT   = 4;
  localparam int SKID_DEPTH = 4;
  localparam int CNT_W      = 8;

  // Value of the VC-id bit that selects each destination.
  localparam logic VC0_ID = 1'b0;
  localparam logic VC1_ID = 1'b1;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int skid_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : vc_pkg
`default_nettype wire

// File: rtl/vcid_demux_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : vcid_demux_if
// Description : Bundle between the Main pop stage / VC FIFOs and the VC-id
//               demux stage.
// Ports       : demux_vcid_in / demux_vcid_valid_in : word + valid from pop
//               VC0_full / VC1_full                  : VC FIFO full flags
//               VCx_data_out / VCx_push              : word + strobe to VC FIFO
//               demux_busy                           : stall hint to pop gate
//               VC0_cnt / VC1_cnt                    : push counters
//               overflow_err                         : sticky drop flag
//               modport slave  : demux stage side
//               modport master : environment side
// Revision    : 1.0 - initial release
// ============================================================================
interface vcid_demux_if
  import vc_pkg::*;
#(
  parameter int DATA_W = vc_pkg::DATA_W,
  parameter int CNT_W  = vc_pkg::CNT_W
);

  logic [DATA_W-1:0] demux_vcid_in;
  logic              demux_vcid_valid_in;
  logic              VC0_full;
  logic              VC1_full;
  logic [DATA_W-1:0] VC0_data_out;
  logic              VC0_push;
  logic [DATA_W-1:0] VC1_data_out;
  logic              VC1_push;
  logic              demux_busy;
  logic [CNT_W-1:0]  VC0_cnt;
  logic [CNT_W-1:0]  VC1_cnt;
  logic              overflow_err;

  modport slave (
    input  demux_vcid_in, demux_vcid_valid_in, VC0_full, VC1_full,
    output VC0_data_out, VC0_push, VC1_data_out, VC1_push,
    output demux_busy, VC0_cnt, VC1_cnt, overflow_err
  );

  modport master (
    output demux_vcid_in, demux_vcid_valid_in, VC0_full, VC1_full,
    input  VC0_data_out, VC0_push, VC1_data_out, VC1_push,
    input  demux_busy, VC0_cnt, VC1_cnt, overflow_err
  );

endinterface : vcid_demux_if
`default_nettype wire

// File: rtl/vcid_demux_stage_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vc_skid_fifo
// Description : Small synchronous FIFO buffering one VC path of the demux.
//               A push while full is accepted only if a pop happens in the
//               same cycle; otherwise it is ignored (caller flags the drop).
// Ports       : clk, reset_L (sync, active-low)
//               push_i / data_i : enqueue request and word
//               pop_i           : dequeue request (ignored when empty)
//               head_o          : oldest stored word
//               count_o         : occupancy 0..SKID_DEPTH
//               full_o / empty_o: occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module vc_skid_fifo
  import vc_pkg::*;
#(
  parameter int DATA_W     = vc_pkg::DATA_W,
  parameter int SKID_DEPTH = vc_pkg::SKID_DEPTH,
  localparam int PTR_W      = $clog2(SKID_DEPTH),
  localparam int SKID_CNT_W = skid_cnt_w(SKID_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic [DATA_W-1:0]     head_o,
  output logic [SKID_CNT_W-1:0] count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam logic [SKID_CNT_W-1:0] C_DEPTH = SKID_CNT_W'(SKID_DEPTH);

  logic [DATA_W-1:0]     mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [SKID_CNT_W-1:0] count_q, count_d;

  logic w_full, w_empty, w_do_push, w_do_pop;

  assign w_full    = (count_q == C_DEPTH);
  assign w_empty   = (count_q == '0);
  assign w_do_pop  = pop_i && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_do_push = push_i && (!w_full || w_do_pop);

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + SKID_CNT_W'(1);
      2'b01:   count_d = count_q - SKID_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (w_do_push) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule : vc_skid_fifo
`default_nettype wire

// File: rtl/vcid_demux_stage.sv
`default_nettype none
// ============================================================================
// Module      : vcid_demux_stage
// Description : Steers words popped from the Main FIFO into the VC0 or VC1
//               FIFO according to the VC-id bit, through one skid FIFO per
//               VC so a downstream full never loses a popped word.
// Ports       : clk     : clock, rising edge
//               reset_L : synchronous active-low reset
//               bus     : vcid_demux_if.slave (input word/valid, VC fulls,
//                         VC push/data, busy, push counters, overflow_err)
// Revision    : 1.0 - initial release
// ============================================================================
module vcid_demux_stage
  import vc_pkg::*;
#(
  parameter int DATA_W     = vc_pkg::DATA_W,
  parameter int VCID_BIT   = vc_pkg::VCID_BIT,
  parameter int SKID_DEPTH = vc_pkg::SKID_DEPTH,
  parameter int CNT_W      = vc_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         reset_L,
  vcid_demux_if.slave  bus
);

  localparam int SKID_CNT_W = skid_cnt_w(SKID_DEPTH);
  // Busy one entry early: the pop stage may still issue a word this cycle.
  localparam logic [SKID_CNT_W-1:0] C_BUSY_THR = SKID_CNT_W'(SKID_DEPTH - 1);

  logic                  w_sel;
  logic [1:0]            w_vc_full;
  logic [1:0]            w_enq;
  logic [1:0]            w_pop;
  logic [1:0]            w_skid_full;
  logic [1:0]            w_skid_empty;
  logic [1:0]            w_busy;
  logic [1:0]            w_drop;
  logic [DATA_W-1:0]     w_head  [2];
  logic [SKID_CNT_W-1:0] w_count [2];
  logic [CNT_W-1:0]      cnt_d   [2];
  logic [CNT_W-1:0]      cnt_q   [2];
  logic                  overflow_d, overflow_q;

  assign w_sel     = bus.demux_vcid_in[VCID_BIT];
  assign w_vc_full = {bus.VC1_full, bus.VC0_full};
  assign w_enq[0]  = bus.demux_vcid_valid_in && (w_sel == VC0_ID);
  assign w_enq[1]  = bus.demux_vcid_valid_in && (w_sel == VC1_ID);

  for (genvar v = 0; v < 2; v++) begin : g_vc
    vc_skid_fifo #(
      .DATA_W     (DATA_W),
      .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
      .clk     (clk),
      .reset_L (reset_L),
      .push_i  (w_enq[v]),
      .pop_i   (w_pop[v]),
      .data_i  (bus.demux_vcid_in),
      .head_o  (w_head[v]),
      .count_o (w_count[v]),
      .full_o  (w_skid_full[v]),
      .empty_o (w_skid_empty[v])
    );

    // Push depends only on skid state and the downstream full flag, so the
    // input word never reaches the outputs combinationally.
    assign w_pop[v]  = !w_skid_empty[v] && !w_vc_full[v];
    assign w_busy[v] = (w_count[v] >= C_BUSY_THR);
    assign w_drop[v] = w_enq[v] && w_skid_full[v] && !w_pop[v];
    assign cnt_d[v]  = cnt_q[v] + (w_pop[v] ? CNT_W'(1) : CNT_W'(0));
  end

  assign overflow_d = overflow_q | (|w_drop);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      overflow_q <= overflow_d;
    end
  end

  assign bus.VC0_push     = w_pop[0];
  assign bus.VC1_push     = w_pop[1];
  assign bus.VC0_data_out = w_pop[0] ? w_head[0] : '0;
  assign bus.VC1_data_out = w_pop[1] ? w_head[1] : '0;
  assign bus.demux_busy   = |w_busy;
  assign bus.VC0_cnt      = cnt_q[0];
  assign bus.VC1_cnt      = cnt_q[1];
  assign bus.overflow_err = overflow_q;

endmodule : vcid_demux_stage
`default_nettype wire

// File: tb/tb_vcid_demux_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_vcid_demux_stage
// Description : Self-checking bench for vcid_demux_stage. A queue-based
//               model of the two skid paths predicts every output each cycle.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vcid_demux_stage;
  import vc_pkg::*;

  logic clk     = 1'b0;
  logic reset_L = 1'b0;

  always #5 clk = ~clk;

  vcid_demux_if bus ();

  vcid_demux_stage dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one queue per VC plus expected counters and flag.
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  logic [CNT_W-1:0]  e_cnt0 = '0;
  logic [CNT_W-1:0]  e_cnt1 = '0;
  logic              e_ovf  = 1'b0;
  bit                model_ok = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then
  // advance the model by the rules applied at the rising edge.
  task automatic cyc(input bit rl, input bit v, input logic [DATA_W-1:0] d,
                     input bit f0, input bit f1);
    bit                ep0, ep1, ebusy;
    logic [DATA_W-1:0] ed0, ed1;
    @(negedge clk);
    reset_L                 = rl;
    bus.demux_vcid_valid_in = v;
    bus.demux_vcid_in       = d;
    bus.VC0_full            = f0;
    bus.VC1_full            = f1;
    #1;
    ep0   = (q0.size() != 0) && !f0;
    ep1   = (q1.size() != 0) && !f1;
    ed0   = ep0 ? q0[0] : '0;
    ed1   = ep1 ? q1[0] : '0;
    ebusy = (q0.size() >= SKID_DEPTH - 1) || (q1.size() >= SKID_DEPTH - 1);
    if (model_ok) begin
      check("VC0_push",     32'(bus.VC0_push),     32'(ep0));
      check("VC0_data_out", 32'(bus.VC0_data_out), 32'(ed0));
      check("VC1_push",     32'(bus.VC1_push),     32'(ep1));
      check("VC1_data_out", 32'(bus.VC1_data_out), 32'(ed1));
      check("demux_busy",   32'(bus.demux_busy),   32'(ebusy));
      check("VC0_cnt",      32'(bus.VC0_cnt),      32'(e_cnt0));
      check("VC1_cnt",      32'(bus.VC1_cnt),      32'(e_cnt1));
      check("overflow_err", 32'(bus.overflow_err), 32'(e_ovf));
    end
    @(posedge clk);
    if (!rl) begin
      q0.delete();
      q1.delete();
      e_cnt0   = '0;
      e_cnt1   = '0;
      e_ovf    = 1'b0;
      model_ok = 1'b1;
    end else begin
      if (ep0) begin void'(q0.pop_front()); e_cnt0 = e_cnt0 + 1'b1; end
      if (ep1) begin void'(q1.pop_front()); e_cnt1 = e_cnt1 + 1'b1; end
      if (v) begin
        if (d[VCID_BIT] == 1'b0) begin
          if (q0.size() < SKID_DEPTH) q0.push_back(d); else e_ovf = 1'b1;
        end else begin
          if (q1.size() < SKID_DEPTH) q1.push_back(d); else e_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n, input bit f0, input bit f1);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, f0, f1);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    bus.demux_vcid_valid_in = 1'b0;
    bus.demux_vcid_in       = '0;
    bus.VC0_full            = 1'b0;
    bus.VC1_full            = 1'b0;

    // Reset held with a valid word present: nothing may be captured.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 6'h15, 1'b0, 1'b0);
    #1;
    check("rst_VC0_cnt", 32'(bus.VC0_cnt), 32'd0);
    check("rst_VC1_cnt", 32'(bus.VC1_cnt), 32'd0);
    idle(2, 1'b0, 1'b0);

    // Routing by bit 4.
    cyc(1'b1, 1'b1, 6'h05, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 6'h13, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    #1;
    check("route_VC0_cnt", 32'(bus.VC0_cnt), 32'd1);
    check("route_VC1_cnt", 32'(bus.VC1_cnt), 32'd1);

    // Stall VC0 with three words, then drain.
    cyc(1'b1, 1'b1, 6'h01, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 6'h02, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 6'h03, 1'b1, 1'b0);
    #1;
    check("stall_busy", 32'(bus.demux_busy), 32'd1);
    idle(1, 1'b1, 1'b0);
    idle(4, 1'b0, 1'b0);
    #1;
    check("drain_busy", 32'(bus.demux_busy), 32'd0);

    // VC0 stalled while VC1 streams.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 6'(6'h10 | i), 1'b1, 1'b0);
    idle(2, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0);

    // Full skid with simultaneous dequeue, then a real overflow.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 6'(6'h0a + i), 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 6'h2e, 1'b0, 1'b0);
    #1;
    check("simul_no_ovf", 32'(bus.overflow_err), 32'd0);
    idle(1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 6'h0f, 1'b1, 1'b0);
    #1;
    check("ovf_set", 32'(bus.overflow_err), 32'd1);
    idle(6, 1'b0, 1'b0);
    #1;
    check("ovf_sticky", 32'(bus.overflow_err), 32'd1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    check("ovf_cleared", 32'(bus.overflow_err), 32'd0);
    idle(1, 1'b0, 1'b0);

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      rd = 6'($urandom);
      cyc(1'b1, ($urandom_range(0, 3) != 0), rd,
          ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3));
    end

    // Mid-operation reset discards buffered words.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 6'(6'h10 | i), 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 6'(i), 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 6'h15, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);

    // 256 VC1 pushes wrap the counter back to zero.
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      rd = 6'($urandom);
      cyc(1'b1, 1'b1, rd | 6'h10, 1'b0, 1'b0);
    end
    idle(2, 1'b0, 1'b0);
    #1;
    check("wrap_VC1_cnt", 32'(bus.VC1_cnt), 32'd0);
    check("wrap_VC0_cnt", 32'(bus.VC0_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_vcid_demux_stage
`default_nettype wire
